// File: rtl/conv_pkg.sv
// Shared types for the tree deserializer: FSM state encoding and the
// bit-reversal helper that maps serial position to parallel lane.
package conv_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Reverse the low 'width' bits of index; bits above 'width' come back zero.
  function automatic logic [31:0] bitrev(input logic [31:0] index, input int unsigned width);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < width; i++) begin
      r[i] = index[width - 1 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_tree_deserializer.sv
// Serial-to-parallel frame assembler, double buffered; PAR_VALID rises 1 CLK after the last bit.
// Backpressure: shifting never stalls; a frame completing while PAR_OUT is held unconsumed is dropped (OVERRUN).
module conv_tree_deserializer
  import conv_pkg::*;
#(
  parameter int OUTPUTS_NUM = 256,
  parameter int STAGES_NUM  = $clog2(OUTPUTS_NUM),
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   SERIAL_IN,
  input  logic                   SERIAL_VALID,
  input  logic                   FRAME_START,
  output logic [OUTPUTS_NUM-1:0] PAR_OUT,
  output logic                   PAR_VALID,
  input  logic                   PAR_READY,
  output logic                   BUSY,
  output logic                   OVERRUN,
  output logic                   FRAME_ERR
);

  localparam logic [STAGES_NUM-1:0] LAST = STAGES_NUM'(OUTPUTS_NUM - 1);

  state_t                 state, state_nxt;
  logic [STAGES_NUM-1:0]  count, count_nxt;
  logic [OUTPUTS_NUM-1:0] shreg, shreg_nxt;
  logic [STAGES_NUM-1:0]  pos, idx;
  logic                   complete;
  logic                   frame_err_nxt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    shreg_nxt     = shreg;
    complete      = 1'b0;
    frame_err_nxt = 1'b0;
    // A frame start always lands in serial position 0, whatever the counter holds.
    pos = FRAME_START ? '0 : count;
    idx = BIT_REVERSE ? STAGES_NUM'(bitrev(32'(pos), STAGES_NUM)) : pos;
    if (SERIAL_VALID) begin
      case (state)
        IDLE: begin
          if (FRAME_START) begin
            shreg_nxt[idx] = SERIAL_IN;
            count_nxt      = STAGES_NUM'(1);
            state_nxt      = SHIFT;
          end
        end
        SHIFT: begin
          shreg_nxt[idx] = SERIAL_IN;
          if (FRAME_START) begin
            frame_err_nxt = 1'b1;
            count_nxt     = STAGES_NUM'(1);
          end else begin
            count_nxt = count + STAGES_NUM'(1);
            if (count == LAST) begin
              complete  = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign BUSY = (state == SHIFT);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count     <= '0;
      shreg     <= '0;
      PAR_OUT   <= '0;
      PAR_VALID <= 1'b0;
      OVERRUN   <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      count     <= count_nxt;
      shreg     <= shreg_nxt;
      FRAME_ERR <= frame_err_nxt;
      OVERRUN   <= 1'b0;
      // Load into an empty buffer or one being drained this same cycle.
      if (complete && (!PAR_VALID || PAR_READY)) begin
        PAR_OUT   <= shreg_nxt;
        PAR_VALID <= 1'b1;
      end else begin
        if (complete) OVERRUN <= 1'b1;
        if (PAR_VALID && PAR_READY) PAR_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: doc/conv_tree_deserializer.md
CONV_TREE_DESERIALIZER -- requirements
Module: conv_tree_deserializer

Interface
REQ-001 SHALL have parameter OUTPUTS_NUM, default 256 (32*8): parallel word width, power of two, >= 2.
REQ-002 SHALL have parameter STAGES_NUM, default $clog2(OUTPUTS_NUM): bit-counter width.
REQ-003 SHALL have parameter BIT_REVERSE, default 1: 1 = tree-serializer ordering (serial bit k -> PAR_OUT[bitrev(k)]); 0 = linear (serial bit k -> PAR_OUT[k]).
REQ-004 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port SERIAL_IN  input  1  serial data bit.
REQ-007 SHALL have port SERIAL_VALID  input  1  SERIAL_IN carries a bit this cycle.
REQ-008 SHALL have port FRAME_START  input  1  qualified by SERIAL_VALID; marks bit 0 of a frame.
REQ-009 SHALL have port PAR_OUT  output  OUTPUTS_NUM  assembled frame, stable while PAR_VALID=1.
REQ-010 SHALL have port PAR_VALID  output  1  PAR_OUT holds an unconsumed frame.
REQ-011 SHALL have port PAR_READY  input  1  consumer accepts; transfer when PAR_VALID and PAR_READY are both 1.
REQ-012 SHALL have port BUSY  output  1  a frame is being shifted in (state SHIFT).
REQ-013 SHALL have port OVERRUN  output  1  one-cycle pulse: a completed frame was dropped.
REQ-014 SHALL have port FRAME_ERR  output  1  one-cycle pulse: FRAME_START arrived mid-frame.

Function
REQ-015 SHALL implement FSM states IDLE and SHIFT, plus a shift register, a bit counter (STAGES_NUM bits) and a separate output register.
REQ-016 In IDLE, SERIAL_VALID=1 with FRAME_START=1 SHALL store bit 0, set count=1 and enter SHIFT; SERIAL_VALID with FRAME_START=0 SHALL be ignored.
REQ-017 In SHIFT, each SERIAL_VALID=1 cycle SHALL store SERIAL_IN at the index given by REQ-003 for serial position count, then increment count; SERIAL_VALID=0 cycles SHALL hold all state.
REQ-018 Storing bit OUTPUTS_NUM-1 SHALL complete the frame, return to IDLE, and wrap count to 0.
REQ-019 On completion, if the output register is empty or is being consumed in the same cycle, SHALL load it so that PAR_VALID=1 from the next cycle (latency 1 CLK after the last bit).
REQ-020 On completion, if PAR_VALID=1 and PAR_READY=0, SHALL drop the new frame, keep PAR_OUT unchanged and pulse OVERRUN for 1 cycle.
REQ-021 SHALL clear PAR_VALID the cycle after a transfer, unless a new frame loads in that same cycle.
REQ-022 Shifting SHALL continue while PAR_VALID=1 (double buffering); back-to-back frames SHALL need no idle gap.
REQ-023 FRAME_START with SERIAL_VALID in SHIFT SHALL abandon the partial frame, pulse FRAME_ERR, store the new bit 0 and set count=1.
REQ-024 PAR_OUT SHALL change only on a load; bits of a partial frame SHALL never appear on PAR_OUT.

Reset
REQ-025 RESET=1 SHALL asynchronously force IDLE, count=0, shift register=0, PAR_OUT=0, PAR_VALID=0, BUSY=0, OVERRUN=0 and FRAME_ERR=0.
REQ-026 Reset asserted mid-frame or while PAR_VALID=1 SHALL discard all data; after release, the first accepted bit SHALL be one with FRAME_START=1.

Structure
REQ-027 SHALL put the state enum typedef and a bitrev(index, width) function in shared package conv_pkg.
REQ-028 SHALL be a single module with no sub-module; the output-buffer logic stays inline.

Verification (bench OUTPUTS_NUM=8)
REQ-029 Serial bits 1,0,0,0,0,0,0,0 with BIT_REVERSE=1 and PAR_READY=1 -> PAR_OUT=8'h01 with PAR_VALID=1 exactly 1 cycle after the 8th bit.
REQ-030 Serial bits 0,1,0,0,0,0,0,0 -> PAR_OUT=8'h10 with BIT_REVERSE=1, and 8'h02 with BIT_REVERSE=0.
REQ-031 PAR_READY=0, frame A=8'hA5 and then frame B sent back-to-back -> PAR_OUT stays 8'hA5, OVERRUN pulses once at B's last bit.
REQ-032 FRAME_START at bit 4 of a frame, followed by a full frame 8'h3C -> FRAME_ERR pulses once and PAR_OUT=8'h3C.
REQ-033 SERIAL_VALID gapped every other cycle for a frame 8'hFF -> PAR_OUT=8'hFF; BUSY=1 from bit 0 to bit 7.
REQ-034 RESET asserted after bit 5 -> all outputs 0 immediately; next frame 8'h81 is received correctly.
